// File: rtl/axi_lite_cmd_master.sv
// AXI-Lite master that queues mixed read/write commands and runs them in order, one at a time.
// Optional per-phase timeout enabled with the AXI_LITE_TIMEOUT_EN macro.
module axi_lite_cmd_master #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int CMD_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_write,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_timeout,
   output logic                busy,
   output logic [2:0]          dbg_state,
   output logic                AWVALID,
   input  logic                AWREADY,
   output logic [ADDR_W-1:0]   AWADDR,
   output logic [2:0]          AWPROT,
   output logic                WVALID,
   input  logic                WREADY,
   output logic [DATA_W-1:0]   WDATA,
   output logic [DATA_W/8-1:0] WSTRB,
   input  logic                BVALID,
   output logic                BREADY,
   input  logic [1:0]          BRESP,
   output logic                ARVALID,
   input  logic                ARREADY,
   output logic [ADDR_W-1:0]   ARADDR,
   output logic [2:0]          ARPROT,
   input  logic                RVALID,
   output logic                RREADY,
   input  logic [DATA_W-1:0]   RDATA,
   input  logic [1:0]          RRESP
);

   // Handshakes: a transfer happens on a rising edge where VALID and READY are both high;
   // every VALID here is decoded from registers only and its payload is held until that edge.

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = $clog2(CMD_DEPTH);
   localparam int PTR_W  = IDX_W + 1;

   if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
      $error("axi_lite_cmd_master: DATA_W must be 32 or 64");
   end
   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("axi_lite_cmd_master: CMD_DEPTH must be a power of 2 and >= 2");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("axi_lite_cmd_master: TIMEOUT_CYC must be >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_DATA = 3'd4,
      S_RSP     = 3'd5
   } state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } cmd_t;

   state_t            state_q, state_d;
   cmd_t              fifo_mem [CMD_DEPTH];
   cmd_t              head, cur;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              full, empty, push, pop, ready_q;
   logic              aw_done, w_done, aw_hs, w_hs, wr_complete;
   logic              rsp_load, tmo_hit, tmo_abort;
   logic              rsp_write_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [1:0]        rsp_resp_q;

   // Extra pointer bit separates full from empty when the index bits match.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
   assign cmd_ready = ready_q && !full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == S_IDLE) && !empty;
   assign head      = fifo_mem[rd_ptr[IDX_W-1:0]];

   assign aw_hs       = AWVALID && AWREADY;
   assign w_hs        = WVALID && WREADY;
   assign wr_complete = (aw_done || aw_hs) && (w_done || w_hs);
   assign rsp_load    = ((state_q == S_WR_RESP) && BVALID) || ((state_q == S_RD_DATA) && RVALID);

   assign AWVALID = (state_q == S_WR) && !aw_done;
   assign WVALID  = (state_q == S_WR) && !w_done;
   assign BREADY  = (state_q == S_WR_RESP);
   assign ARVALID = (state_q == S_RD_ADDR);
   assign RREADY  = (state_q == S_RD_DATA);
   assign AWADDR  = cur.addr;
   assign ARADDR  = cur.addr;
   assign WDATA   = cur.wdata;
   assign WSTRB   = cur.wstrb;
   assign AWPROT  = 3'b000;
   assign ARPROT  = 3'b000;

   assign rsp_valid = (state_q == S_RSP);
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;
   assign busy      = (state_q != S_IDLE) || !empty;
   assign dbg_state = state_q;

   // A handshake completing on the timeout cycle takes priority over the abort.
   always_comb begin
      state_d   = state_q;
      tmo_abort = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) state_d = head.write ? S_WR : S_RD_ADDR;
         end
         S_WR: begin
            if (wr_complete) state_d = S_WR_RESP;
            else if (tmo_hit) begin
               state_d   = S_RSP;
               tmo_abort = 1'b1;
            end
         end
         S_WR_RESP: begin
            if (BVALID) state_d = S_RSP;
            else if (tmo_hit) begin
               state_d   = S_RSP;
               tmo_abort = 1'b1;
            end
         end
         S_RD_ADDR: begin
            if (ARREADY) state_d = S_RD_DATA;
            else if (tmo_hit) begin
               state_d   = S_RSP;
               tmo_abort = 1'b1;
            end
         end
         S_RD_DATA: begin
            if (RVALID) state_d = S_RSP;
            else if (tmo_hit) begin
               state_d   = S_RSP;
               tmo_abort = 1'b1;
            end
         end
         S_RSP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (push) fifo_mem[wr_ptr[IDX_W-1:0]] <= cmd_t'({cmd_write, cmd_addr, cmd_wdata, cmd_wstrb});
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q     <= S_IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ready_q     <= 1'b0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         cur         <= '0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         ready_q <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            cur     <= head;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs) w_done <= 1'b1;
         if (state_q == S_WR_RESP && BVALID) begin
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= BRESP;
         end else if (state_q == S_RD_DATA && RVALID) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= RDATA;
            rsp_resp_q  <= RRESP;
         end else if (tmo_abort) begin
            rsp_write_q <= cur.write;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b10;
         end
      end
   end

`ifdef AXI_LITE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
   logic [TMO_W-1:0] tmo_cnt;
   logic             wait_state;
   logic             rsp_timeout_q;

   assign wait_state = (state_q == S_WR) || (state_q == S_WR_RESP) ||
                       (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
   assign tmo_hit    = wait_state && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   // Restarting on every state change gives each phase its own full budget.
   always_ff @(posedge ACLK) begin
      if (!ARESETn || state_d != state_q) tmo_cnt <= '0;
      else if (wait_state) tmo_cnt <= tmo_cnt + TMO_W'(1);
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) rsp_timeout_q <= 1'b0;
      else if (rsp_load) rsp_timeout_q <= 1'b0;
      else if (tmo_abort) rsp_timeout_q <= 1'b1;
   end
   assign rsp_timeout = rsp_timeout_q;
`else
   assign tmo_hit     = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: single write/read, delayed AW, FIFO fill, reset mid-flight
// and (with AXI_LITE_TIMEOUT_EN) a read address timeout.
module tb_axi_lite_cmd_master;

   logic        ACLK;
   logic        ARESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [2:0]  dbg_state;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [3:0]  WSTRB;
   logic [2:0]  AWPROT, ARPROT;
   logic [1:0]  BRESP, RRESP;

   int checks = 0;
   int errors = 0;
   logic [34:0] exp_q[$];

   axi_lite_cmd_master #(
      .ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4)
`ifdef AXI_LITE_TIMEOUT_EN
      , .TIMEOUT_CYC(16)
`endif
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .busy(busy), .dbg_state(dbg_state),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = s;
   endtask

   task automatic consume_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   // Slave accepts immediately and answers with the given values; response checked against exp_q head.
   task automatic serve(input logic [31:0] exp_addr, input logic [31:0] s_rdata, input logic [1:0] s_resp);
      logic got;
      logic addr_seen;
      logic [34:0] e;
      got = 1'b0;
      addr_seen = 1'b0;
      AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         BVALID = BREADY; BRESP = s_resp;
         RVALID = RREADY; RDATA = s_rdata; RRESP = s_resp;
         if (!addr_seen && AWVALID) begin
            chk("serve_awaddr", AWADDR, exp_addr);
            addr_seen = 1'b1;
         end
         if (!addr_seen && ARVALID) begin
            chk("serve_araddr", ARADDR, exp_addr);
            addr_seen = 1'b1;
         end
         if (rsp_valid) begin
            e = exp_q.pop_front();
            chk("serve_rsp_write", rsp_write, e[34]);
            chk("serve_rsp_rdata", rsp_rdata, e[33:2]);
            chk("serve_rsp_resp", rsp_resp, e[1:0]);
            chk("serve_rsp_timeout", rsp_timeout, 1'b0);
            rsp_ready = 1'b1;
            got = 1'b1;
         end
         step();
         rsp_ready = 1'b0; BVALID = 1'b0; RVALID = 1'b0;
      end
      chk("serve_got_rsp", got, 1'b1);
      AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
   endtask

   initial begin
      ARESETn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0;
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
      ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;

      // reset state
      step(); step();
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_awvalid", AWVALID, 1'b0);
      chk("rst_arvalid", ARVALID, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_state", dbg_state, 3'd0);
      ARESETn = 1'b1;
      step();
      chk("rel_cmd_ready", cmd_ready, 1'b1);

      // single write, slave ready immediately
      AWREADY = 1'b1; WREADY = 1'b1;
      set_cmd(1'b1, 32'hFFFF_0008, 32'h3000_0000, 4'hF);
      step();
      cmd_valid = 1'b0;
      chk("w1_awvalid_pushcyc", AWVALID, 1'b0);
      chk("w1_busy", busy, 1'b1);
      step();
      chk("w1_awvalid", AWVALID, 1'b1);
      chk("w1_wvalid", WVALID, 1'b1);
      chk("w1_awaddr", AWADDR, 32'hFFFF_0008);
      chk("w1_wdata", WDATA, 32'h3000_0000);
      chk("w1_wstrb", WSTRB, 4'hF);
      chk("w1_awprot", AWPROT, 3'b000);
      step();
      AWREADY = 1'b0; WREADY = 1'b0;
      chk("w1_awvalid_done", AWVALID, 1'b0);
      chk("w1_wvalid_done", WVALID, 1'b0);
      chk("w1_bready", BREADY, 1'b1);
      BVALID = 1'b1; BRESP = 2'b00;
      step();
      BVALID = 1'b0;
      chk("w1_rsp_valid", rsp_valid, 1'b1);
      chk("w1_rsp_write", rsp_write, 1'b1);
      chk("w1_rsp_resp", rsp_resp, 2'b00);
      chk("w1_rsp_rdata", rsp_rdata, 32'h0);
      chk("w1_rsp_timeout", rsp_timeout, 1'b0);
      chk("w1_bready_rsp", BREADY, 1'b0);
      consume_rsp();
      chk("w1_rsp_valid_done", rsp_valid, 1'b0);
      chk("w1_busy_done", busy, 1'b0);

      // write with AWREADY delayed: W completes first, AW held 3 cycles
      WREADY = 1'b1;
      set_cmd(1'b1, 32'h0000_0010, 32'h1234_5678, 4'h3);
      step();
      cmd_valid = 1'b0;
      step();
      chk("w2_awvalid_c1", AWVALID, 1'b1);
      chk("w2_wvalid_c1", WVALID, 1'b1);
      step();
      WREADY = 1'b0;
      chk("w2_wvalid_c2", WVALID, 1'b0);
      chk("w2_awvalid_c2", AWVALID, 1'b1);
      step();
      chk("w2_awvalid_c3", AWVALID, 1'b1);
      chk("w2_bready_c3", BREADY, 1'b0);
      AWREADY = 1'b1;
      step();
      AWREADY = 1'b0;
      chk("w2_awvalid_done", AWVALID, 1'b0);
      chk("w2_bready", BREADY, 1'b1);
      BVALID = 1'b1; BRESP = 2'b10;
      step();
      BVALID = 1'b0;
      chk("w2_rsp_valid", rsp_valid, 1'b1);
      chk("w2_rsp_write", rsp_write, 1'b1);
      chk("w2_rsp_resp", rsp_resp, 2'b10);
      step();
      chk("w2_rsp_hold", rsp_valid, 1'b1);
      chk("w2_rsp_resp_hold", rsp_resp, 2'b10);
      consume_rsp();
      chk("w2_single_rsp", rsp_valid, 1'b0);
      chk("w2_busy_done", busy, 1'b0);

      // single read
      ARREADY = 1'b1;
      set_cmd(1'b0, 32'hFFFF_0004, 32'hDEAD_BEEF, 4'h0);
      step();
      cmd_valid = 1'b0;
      chk("r1_arvalid_pushcyc", ARVALID, 1'b0);
      step();
      chk("r1_arvalid", ARVALID, 1'b1);
      chk("r1_araddr", ARADDR, 32'hFFFF_0004);
      chk("r1_arprot", ARPROT, 3'b000);
      chk("r1_awvalid", AWVALID, 1'b0);
      step();
      ARREADY = 1'b0;
      chk("r1_arvalid_done", ARVALID, 1'b0);
      chk("r1_rready", RREADY, 1'b1);
      RVALID = 1'b1; RDATA = 32'h0000_00A5; RRESP = 2'b00;
      step();
      RVALID = 1'b0;
      chk("r1_rsp_valid", rsp_valid, 1'b1);
      chk("r1_rsp_rdata", rsp_rdata, 32'h0000_00A5);
      chk("r1_rsp_write", rsp_write, 1'b0);
      chk("r1_rsp_resp", rsp_resp, 2'b00);
      consume_rsp();

      // five back-to-back commands with slave stalled: first pops, four fill the FIFO
      set_cmd(1'b1, 32'h20, 32'h1111_1111, 4'hF); exp_q.push_back({1'b1, 32'h0, 2'b00});
      chk("f_ready_0", cmd_ready, 1'b1);
      step();
      set_cmd(1'b0, 32'h24, 32'h0, 4'h0);         exp_q.push_back({1'b0, 32'hCAFE_0001, 2'b00});
      chk("f_ready_1", cmd_ready, 1'b1);
      step();
      set_cmd(1'b1, 32'h28, 32'h2222_2222, 4'h5); exp_q.push_back({1'b1, 32'h0, 2'b01});
      chk("f_ready_2", cmd_ready, 1'b1);
      step();
      set_cmd(1'b0, 32'h2C, 32'h0, 4'h0);         exp_q.push_back({1'b0, 32'hCAFE_0003, 2'b10});
      chk("f_ready_3", cmd_ready, 1'b1);
      step();
      set_cmd(1'b0, 32'h30, 32'h0, 4'h0);         exp_q.push_back({1'b0, 32'h0000_00FF, 2'b11});
      chk("f_ready_4", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
      chk("f_full", cmd_ready, 1'b0);
      chk("f_stall_awvalid", AWVALID, 1'b1);
      chk("f_stall_awaddr", AWADDR, 32'h20);
      step();
      chk("f_full_hold", cmd_ready, 1'b0);
      serve(32'h20, 32'h0, 2'b00);
      serve(32'h24, 32'hCAFE_0001, 2'b00);
      serve(32'h28, 32'h0, 2'b01);
      serve(32'h2C, 32'hCAFE_0003, 2'b10);
      serve(32'h30, 32'h0000_00FF, 2'b11);
      chk("f_queue_empty", exp_q.size(), 0);
      chk("f_ready_after", cmd_ready, 1'b1);
      chk("f_busy_after", busy, 1'b0);

      // reset while waiting in WR_RESP with another command queued
      AWREADY = 1'b1; WREADY = 1'b1;
      set_cmd(1'b1, 32'h40, 32'hA5A5_A5A5, 4'hF);
      step();
      set_cmd(1'b0, 32'h44, 32'h0, 4'h0);
      step();
      cmd_valid = 1'b0;
      step();
      AWREADY = 1'b0; WREADY = 1'b0;
      chk("rm_bready", BREADY, 1'b1);
      chk("rm_busy", busy, 1'b1);
      ARESETn = 1'b0;
      step();
      ARESETn = 1'b1;
      chk("rm_awvalid", AWVALID, 1'b0);
      chk("rm_wvalid", WVALID, 1'b0);
      chk("rm_bready_rst", BREADY, 1'b0);
      chk("rm_busy_rst", busy, 1'b0);
      chk("rm_rsp_valid", rsp_valid, 1'b0);
      chk("rm_cmd_ready_rst", cmd_ready, 1'b0);
      step();
      chk("rm_cmd_ready_rel", cmd_ready, 1'b1);
      chk("rm_fifo_empty", busy, 1'b0);
      chk("rm_arvalid", ARVALID, 1'b0);
      chk("rm_state", dbg_state, 3'd0);

`ifdef AXI_LITE_TIMEOUT_EN
      // read whose address is never accepted: aborts after 16 cycles of ARVALID
      set_cmd(1'b0, 32'hFFFF_0004, 32'h0, 4'h0);
      step();
      cmd_valid = 1'b0;
      step();
      for (int k = 0; k < 16; k++) begin
         chk("to_arvalid_held", ARVALID, 1'b1);
         step();
      end
      chk("to_arvalid_drop", ARVALID, 1'b0);
      chk("to_rsp_valid", rsp_valid, 1'b1);
      chk("to_rsp_timeout", rsp_timeout, 1'b1);
      chk("to_rsp_resp", rsp_resp, 2'b10);
      chk("to_rsp_rdata", rsp_rdata, 32'h0);
      chk("to_rsp_write", rsp_write, 1'b0);
      consume_rsp();
      chk("to_busy_done", busy, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
